// File: rtl/prime_feed_sched_pkg.sv
// ----------------------------------------------------------------------------
// prime_feed_sched_pkg
// Shared constants for the prime_feed scheduler: FSM state encoding and
// default configuration values for the data width, requester count and
// watchdog limit.
// ----------------------------------------------------------------------------
package prime_feed_sched_pkg;

    // Scheduler FSM states (2-bit encoding)
    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] ISSUE   = 2'd1;
    localparam logic [1:0] WAIT    = 2'd2;
    localparam logic [1:0] DELIVER = 2'd3;

    // Default configuration
    localparam int DEF_WIDTH          = 512;
    localparam int DEF_NUM_REQ        = 4;
    localparam int DEF_TIMEOUT_CYCLES = 1024;

endpackage

// File: rtl/prime_feed_sched_rr_arbiter.sv
// ----------------------------------------------------------------------------
// rr_arbiter
// Purely combinational round-robin pick: returns the one-hot grant of the
// first asserted request at or after `pointer`, wrapping past NUM_REQ-1.
// Ports:
//   req     in  NUM_REQ  request vector
//   pointer in  PW       round-robin start position (0..NUM_REQ-1)
//   gnt     out NUM_REQ  one-hot grant (all zero when no request)
//   any_req out 1        at least one request is asserted
// ----------------------------------------------------------------------------
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int PW      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [PW-1:0]      pointer,
    output logic [NUM_REQ-1:0] gnt,
    output logic               any_req
);

    logic [PW:0]   sum_s;
    logic [PW-1:0] idx_s;
    logic          found_s;

    // Scan positions pointer, pointer+1, ... (mod NUM_REQ) and grant the first hit
    always_comb begin
        gnt     = '0;
        found_s = 1'b0;
        sum_s   = '0;
        idx_s   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            sum_s = {1'b0, pointer} + (PW+1)'(i);
            if (sum_s >= (PW+1)'(NUM_REQ)) begin
                sum_s = sum_s - (PW+1)'(NUM_REQ);
            end else begin
                sum_s = sum_s;
            end
            idx_s = sum_s[PW-1:0];
            if (!found_s && req[idx_s]) begin
                gnt[idx_s] = 1'b1;
                found_s    = 1'b1;
            end else begin
                found_s = found_s;
            end
        end
    end

    assign any_req = |req;

endmodule

// File: rtl/prime_feed_sched.sv
// ----------------------------------------------------------------------------
// prime_feed_sched
// Round-robin scheduler sharing one prime_feed source among NUM_REQ key-gen
// requesters. One feed transaction in flight at a time:
//   IDLE -> (grant) ISSUE (feed_next pulse) -> WAIT (for feed_ready, capture)
//   -> DELIVER (done pulse, pointer advance) -> IDLE.
// All outputs are registered.
// Optional feature: define PRIME_FEED_SCHED_TIMEOUT_EN to add a WAIT-state
// watchdog of TIMEOUT_CYCLES cycles that sets sticky timeout_err and delivers
// done with out_* unchanged. Without it, WAIT holds indefinitely and
// timeout_err is tied to 0.
// Ports:
//   aclk, areset        clock, synchronous active-high reset
//   req[NUM_REQ]        level requests, held until done
//   grant[NUM_REQ]      one-hot grant held for the whole transaction
//   done[NUM_REQ]       one-cycle pulse on the granted bit
//   feed_next           one-cycle pulse to prime_feed
//   feed_ready, feed_p/q/r/s  prime_feed results
//   out_p/q/r/s         captured primes, stable until next capture
//   busy                high when not IDLE
//   timeout_err         sticky watchdog flag
// ----------------------------------------------------------------------------
module prime_feed_sched
    import prime_feed_sched_pkg::*;
#(
    parameter int WIDTH          = DEF_WIDTH,
    parameter int NUM_REQ        = DEF_NUM_REQ,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic               aclk,
    input  logic               areset,
    input  logic [NUM_REQ-1:0] req,
    output logic [NUM_REQ-1:0] grant,
    output logic [NUM_REQ-1:0] done,
    output logic               feed_next,
    input  logic               feed_ready,
    input  logic [WIDTH-1:0]   feed_p,
    input  logic [WIDTH-1:0]   feed_q,
    input  logic [WIDTH-1:0]   feed_r,
    input  logic [WIDTH-1:0]   feed_s,
    output logic [WIDTH-1:0]   out_p,
    output logic [WIDTH-1:0]   out_q,
    output logic [WIDTH-1:0]   out_r,
    output logic [WIDTH-1:0]   out_s,
    output logic               busy,
    output logic               timeout_err
);

    localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [1:0]         state_r, next_state_s;
    logic [PW-1:0]      ptr_r, ptr_nxt_s;
    logic [NUM_REQ-1:0] grant_r, grant_nxt_s;
    logic [NUM_REQ-1:0] done_r, done_nxt_s;
    logic               feed_next_r, feed_next_nxt_s;
    logic               capture_s;
    logic               busy_r;
    logic [WIDTH-1:0]   out_p_r, out_q_r, out_r_r, out_s_r;
    logic [NUM_REQ-1:0] arb_gnt_s;
    logic               any_req_s;
    logic               timeout_hit_s;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .PW      (PW)
    ) u_arb (
        .req     (req),
        .pointer (ptr_r),
        .gnt     (arb_gnt_s),
        .any_req (any_req_s)
    );

`ifdef PRIME_FEED_SCHED_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    logic [CW-1:0] wd_cnt_r;
    logic          timeout_err_r;

    // Fires in the WAIT cycle whose increment makes the count reach TIMEOUT_CYCLES
    assign timeout_hit_s = (state_r == WAIT) && !feed_ready &&
                           (wd_cnt_r == CW'(TIMEOUT_CYCLES - 1));

    // Watchdog counter (zero outside WAIT, so it is clear on WAIT entry) and sticky error
    always_ff @(posedge aclk) begin
        if (areset) begin
            wd_cnt_r      <= '0;
            timeout_err_r <= 1'b0;
        end else begin
            if (state_r == WAIT) begin
                wd_cnt_r <= wd_cnt_r + CW'(1);
            end else begin
                wd_cnt_r <= '0;
            end
            if (timeout_hit_s) begin
                timeout_err_r <= 1'b1;
            end else begin
                timeout_err_r <= timeout_err_r;
            end
        end
    end

    assign timeout_err = timeout_err_r;
`else
    assign timeout_hit_s = 1'b0;
    assign timeout_err   = 1'b0;
`endif

    // State register plus registered outputs
    always_ff @(posedge aclk) begin
        if (areset) begin
            state_r     <= IDLE;
            ptr_r       <= '0;
            grant_r     <= '0;
            done_r      <= '0;
            feed_next_r <= 1'b0;
            busy_r      <= 1'b0;
            out_p_r     <= '0;
            out_q_r     <= '0;
            out_r_r     <= '0;
            out_s_r     <= '0;
        end else begin
            state_r     <= next_state_s;
            ptr_r       <= ptr_nxt_s;
            grant_r     <= grant_nxt_s;
            done_r      <= done_nxt_s;
            feed_next_r <= feed_next_nxt_s;
            busy_r      <= (next_state_s != IDLE);
            if (capture_s) begin
                out_p_r <= feed_p;
                out_q_r <= feed_q;
                out_r_r <= feed_r;
                out_s_r <= feed_s;
            end else begin
                out_p_r <= out_p_r;
                out_q_r <= out_q_r;
                out_r_r <= out_r_r;
                out_s_r <= out_s_r;
            end
        end
    end

    // Next-state logic
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            IDLE:    next_state_s = any_req_s ? ISSUE : IDLE;
            ISSUE:   next_state_s = WAIT;
            WAIT:    next_state_s = (feed_ready || timeout_hit_s) ? DELIVER : WAIT;
            DELIVER: next_state_s = IDLE;
            default: next_state_s = IDLE;
        endcase
    end

    // Next values for the registered outputs; feed_ready outside WAIT is ignored
    always_comb begin
        grant_nxt_s     = grant_r;
        done_nxt_s      = '0;
        feed_next_nxt_s = 1'b0;
        capture_s       = 1'b0;
        ptr_nxt_s       = ptr_r;
        case (state_r)
            IDLE: begin
                if (any_req_s) begin
                    grant_nxt_s     = arb_gnt_s;
                    feed_next_nxt_s = 1'b1;
                end else begin
                    grant_nxt_s = '0;
                end
            end
            ISSUE: begin
                grant_nxt_s = grant_r;
            end
            WAIT: begin
                if (feed_ready) begin
                    capture_s  = 1'b1;
                    done_nxt_s = grant_r;
                end else if (timeout_hit_s) begin
                    done_nxt_s = grant_r;
                end else begin
                    done_nxt_s = '0;
                end
            end
            DELIVER: begin
                grant_nxt_s = '0;
                // Pointer moves to the position just after the served requester
                for (int i = 0; i < NUM_REQ; i++) begin
                    if (grant_r[i]) begin
                        ptr_nxt_s = (i == NUM_REQ - 1) ? '0 : PW'(i + 1);
                    end else begin
                        ptr_nxt_s = ptr_nxt_s;
                    end
                end
            end
            default: begin
                grant_nxt_s = '0;
            end
        endcase
    end

    assign grant     = grant_r;
    assign done      = done_r;
    assign feed_next = feed_next_r;
    assign busy      = busy_r;
    assign out_p     = out_p_r;
    assign out_q     = out_q_r;
    assign out_r     = out_r_r;
    assign out_s     = out_s_r;

endmodule

// File: tb/tb_prime_feed_sched.sv
`timescale 1ns/1ps
// ----------------------------------------------------------------------------
// tb_prime_feed_sched
// Self-checking bench: directed scenarios followed by randomized
// transactions, compared against a transaction-level reference model
// (pending-request set, round-robin pointer, last captured primes).
// ----------------------------------------------------------------------------
module tb_prime_feed_sched;

    localparam int W  = 64;
    localparam int N  = 4;
    localparam int TO = 16;

    logic         aclk = 1'b0;
    logic         areset;
    logic [N-1:0] req;
    logic [N-1:0] grant;
    logic [N-1:0] done;
    logic         feed_next;
    logic         feed_ready;
    logic [W-1:0] feed_p, feed_q, feed_r, feed_s;
    logic [W-1:0] out_p, out_q, out_r, out_s;
    logic         busy;
    logic         timeout_err;

    int checks = 0;
    int errors = 0;

    // Reference model state
    int           ptr_m;
    logic [N-1:0] pend_m;
    logic [W-1:0] exp_p, exp_q, exp_r, exp_s;
    logic         exp_terr;
    int           waited [N];

    always #5 aclk = ~aclk;

    prime_feed_sched #(
        .WIDTH          (W),
        .NUM_REQ        (N),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .aclk        (aclk),
        .areset      (areset),
        .req         (req),
        .grant       (grant),
        .done        (done),
        .feed_next   (feed_next),
        .feed_ready  (feed_ready),
        .feed_p      (feed_p),
        .feed_q      (feed_q),
        .feed_r      (feed_r),
        .feed_s      (feed_s),
        .out_p       (out_p),
        .out_q       (out_q),
        .out_r       (out_r),
        .out_s       (out_s),
        .busy        (busy),
        .timeout_err (timeout_err)
    );

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    function automatic logic [W-1:0] rnd();
        return {$urandom, $urandom};
    endfunction

    function automatic logic [N-1:0] onehot(input int g);
        logic [N-1:0] v;
        v = '0;
        v[g] = 1'b1;
        return v;
    endfunction

    // First pending requester at or after ptr, wrapping
    function automatic int pick(input logic [N-1:0] p, input int ptr);
        for (int k = 0; k < N; k++) begin
            if (p[(ptr + k) % N]) return (ptr + k) % N;
        end
        return -1;
    endfunction

    task automatic check_idle(input string tag);
        check({tag, ".busy"},  W'(busy), '0);
        check({tag, ".grant"}, W'(grant), '0);
        check({tag, ".done"},  W'(done), '0);
        check({tag, ".next"},  W'(feed_next), '0);
        check({tag, ".out_p"}, out_p, exp_p);
        check({tag, ".out_q"}, out_q, exp_q);
        check({tag, ".out_r"}, out_r, exp_r);
        check({tag, ".out_s"}, out_s, exp_s);
        check({tag, ".terr"},  W'(timeout_err), W'(exp_terr));
    endtask

    task automatic model_reset();
        ptr_m    = 0;
        pend_m   = '0;
        exp_p    = '0;
        exp_q    = '0;
        exp_r    = '0;
        exp_s    = '0;
        exp_terr = 1'b0;
        for (int i = 0; i < N; i++) waited[i] = 0;
    endtask

    task automatic do_reset(input string tag);
        areset     = 1'b1;
        req        = '0;
        feed_ready = 1'b0;
        tick();
        areset = 1'b0;
        model_reset();
        check_idle(tag);
    endtask

    // Called in an IDLE cycle; returns in the first WAIT cycle with the expected grantee
    task automatic start(input string tag, input logic [N-1:0] newreq, input bit stray, output int g);
        for (int i = 0; i < N; i++) begin
            if (newreq[i] && !pend_m[i]) waited[i] = 0;
        end
        pend_m = pend_m | newreq;
        req    = pend_m;
        if (stray) begin
            feed_ready = 1'b1;
            feed_p = rnd(); feed_q = rnd(); feed_r = rnd(); feed_s = rnd();
        end
        g = pick(pend_m, ptr_m);
        tick();
        feed_ready = 1'b0;
        check({tag, ".grant"}, W'(grant), W'(onehot(g)));
        check({tag, ".next"},  W'(feed_next), 1);
        check({tag, ".busy"},  W'(busy), 1);
        check({tag, ".done0"}, W'(done), '0);
        check({tag, ".hold_p"}, out_p, exp_p);
        tick();
        check({tag, ".next_off"}, W'(feed_next), '0);
        check({tag, ".grant_w"},  W'(grant), W'(onehot(g)));
    endtask

    // Served requester bookkeeping: fairness bound and pointer advance
    task automatic serve(input string tag, input int g, input bit keep_after);
        check({tag, ".fair"}, W'(waited[g] > N - 1), '0);
        for (int i = 0; i < N; i++) begin
            if (i != g && pend_m[i]) waited[i]++;
        end
        waited[g] = 0;
        if (!keep_after) pend_m[g] = 1'b0;
        req   = pend_m;
        ptr_m = (g + 1) % N;
    endtask

    // From the first WAIT cycle: d more WAIT cycles, then feed_ready, DELIVER, back to IDLE
    task automatic finish(input string tag, input int g, input int d, input bit drop_mid, input bit keep_after);
        logic [W-1:0] p, q, r, s;
        if (drop_mid) begin
            pend_m[g] = 1'b0;
            req       = pend_m;
        end
        repeat (d) begin
            tick();
            check({tag, ".wait_done"},  W'(done), '0);
            check({tag, ".wait_grant"}, W'(grant), W'(onehot(g)));
        end
        p = rnd(); q = rnd(); r = rnd(); s = rnd();
        feed_ready = 1'b1;
        feed_p = p; feed_q = q; feed_r = r; feed_s = s;
        tick();
        feed_ready = 1'b0;
        exp_p = p; exp_q = q; exp_r = r; exp_s = s;
        check({tag, ".done"},  W'(done), W'(onehot(g)));
        check({tag, ".out_p"}, out_p, exp_p);
        check({tag, ".out_q"}, out_q, exp_q);
        check({tag, ".out_r"}, out_r, exp_r);
        check({tag, ".out_s"}, out_s, exp_s);
        check({tag, ".busy_d"}, W'(busy), 1);
        serve(tag, g, keep_after);
        tick();
        check_idle({tag, ".idle"});
    endtask

    task automatic idle_stray(input string tag, input logic [W-1:0] val);
        feed_ready = 1'b1;
        feed_p = val; feed_q = val; feed_r = val; feed_s = val;
        tick();
        feed_ready = 1'b0;
        check_idle({tag, ".a"});
        tick();
        check_idle({tag, ".b"});
    endtask

    initial begin
        int g;
        logic [N-1:0] nr;
        areset = 1'b1;
        req = '0;
        feed_ready = 1'b0;
        feed_p = '0; feed_q = '0; feed_r = '0; feed_s = '0;
        model_reset();
        tick();
        do_reset("reset");

        // Contention: all four held, strict rotation from pointer 0
        for (int k = 0; k < 5; k++) begin
            start("T2", (k == 0) ? 4'b1111 : 4'b0000, 1'b0, g);
            check("T2.order", W'(g), W'(k % N));
            finish("T2", g, 1, 1'b0, 1'b1);
        end
        do_reset("reset2");

        // Single request, feed_ready four WAIT cycles after entry
        start("T1", 4'b0010, 1'b0, g);
        finish("T1", g, 4, 1'b0, 1'b0);

        // Stray feed_ready while idle
        idle_stray("T3", 64'd5);

        // Request dropped during WAIT still gets done; pointer then at 3
        start("T6", 4'b0100, 1'b0, g);
        finish("T6", g, 2, 1'b1, 1'b0);
        start("T6b", 4'b1011, 1'b0, g);
        check("T6.ptr", W'(g), 3);
        finish("T6b", g, 0, 1'b0, 1'b0);
        start("T6c", 4'b0000, 1'b0, g);
        finish("T6c", g, 0, 1'b0, 1'b0);
        start("T6d", 4'b0000, 1'b0, g);
        finish("T6d", g, 0, 1'b0, 1'b0);

        // Reset in WAIT cycle 2, then a late feed_ready
        start("T4", 4'b0001, 1'b0, g);
        tick();
        areset = 1'b1;
        req    = '0;
        tick();
        areset = 1'b0;
        model_reset();
        check_idle("T4.rst");
        feed_ready = 1'b1;
        feed_p = rnd(); feed_q = rnd(); feed_r = rnd(); feed_s = rnd();
        tick();
        feed_ready = 1'b0;
        check_idle("T4.late");

`ifdef PRIME_FEED_SCHED_TIMEOUT_EN
        // Watchdog: no feed_ready, done 16 cycles after WAIT entry
        start("T5", 4'b0001, 1'b0, g);
        check("T5.w0", W'(done), '0);
        repeat (TO - 1) begin
            tick();
            check("T5.wait", W'(done), '0);
        end
        tick();
        check("T5.done", W'(done), W'(onehot(g)));
        check("T5.terr", W'(timeout_err), 1);
        check("T5.out_p", out_p, exp_p);
        exp_terr = 1'b1;
        serve("T5", g, 1'b0);
        tick();
        check_idle("T5.idle");
        start("T5n", 4'b0100, 1'b0, g);
        finish("T5n", g, 1, 1'b0, 1'b0);
`endif

        // Randomized traffic
        for (int it = 0; it < 60; it++) begin
            if (pend_m == '0 && $urandom_range(0, 3) == 0) begin
                idle_stray("rnd_stray", rnd());
            end
            nr = N'($urandom_range(0, 15));
            if ((pend_m | nr) == '0) nr = onehot($urandom_range(0, N - 1));
            start("rnd", nr, 1'($urandom_range(0, 1)), g);
            finish("rnd", g, $urandom_range(0, 5), ($urandom_range(0, 3) == 0), 1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
